// File: rtl/bot_nav_ctrl.sv
// Rojobot autopilot: snapshots BOTSIM registers on each update toggle
// and runs line-follow / obstacle-avoid navigation onto MotCtl.
module bot_nav_ctrl #(
    parameter logic [2:0] FWD_SPD      = 3'd3,
    parameter logic [2:0] TURN_SPD     = 3'd2,
    parameter logic [7:0] BACK_UPDS    = 8'd4,
    parameter logic [7:0] TURN_UPDS    = 8'd6,
    parameter logic [7:0] SEARCH_LIMIT = 8'd32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        upd_sysregs,
    input  logic [7:0]  LocX,
    input  logic [7:0]  LocY,
    input  logic [7:0]  BotInfo,
    input  logic [7:0]  Sensors,
    output logic [7:0]  MotCtl,
    output logic [2:0]  nav_state,
    output logic        upd_ack,
    output logic [15:0] snap_loc
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FOLLOW = 3'd1,
        SEARCH = 3'd2,
        BACKUP = 3'd3,
        TURN   = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef struct packed {
        state_t     st;
        logic [7:0] mot;
        logic [7:0] cnt;
        logic       side;
    } dec_t;

    localparam logic [7:0] STRAIGHT = {FWD_SPD, 1'b1, FWD_SPD, 1'b1};
    localparam logic [7:0] VEER_L   = {TURN_SPD, 1'b1, FWD_SPD, 1'b1};
    localparam logic [7:0] VEER_R   = {FWD_SPD, 1'b1, TURN_SPD, 1'b1};
    localparam logic [7:0] SPIN_L   = {TURN_SPD, 1'b0, TURN_SPD, 1'b1};
    localparam logic [7:0] SPIN_R   = {TURN_SPD, 1'b1, TURN_SPD, 1'b0};
    localparam logic [7:0] REV      = {TURN_SPD, 1'b0, TURN_SPD, 1'b0};
    localparam logic [7:0] STOP     = 8'h00;

    state_t     state;
    logic       upd_q;
    logic       evt;
    logic       evt_d;
    logic [4:0] snap_sens;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic       last_side;
    logic [2:0] line;
    logic       prox;
    dec_t       fr;
    logic       unused_ok;

    function automatic dec_t follow(
        input logic [2:0] ln,
        input logic       px,
        input logic       side
    );
        dec_t d;
        d = '{st: FOLLOW, mot: STRAIGHT, cnt: 8'd0, side: side};
        if (px) begin
            d.st  = BACKUP;
            d.mot = REV;
            d.cnt = 8'd1;
        end else if (ln == 3'b000) begin
            d.st  = SEARCH;
            d.mot = side ? SPIN_R : SPIN_L;
            d.cnt = 8'd1;
        end else if (ln[1] || ln == 3'b101 || ln == 3'b111) begin
            d.mot = STRAIGHT;
        end else if (ln == 3'b100) begin
            d.mot  = VEER_L;
            d.side = 1'b0;
        end else begin
            d.mot  = VEER_R;
            d.side = 1'b1;
        end
        return d;
    endfunction

    assign evt       = upd_sysregs ^ upd_q;
    assign line      = ~snap_sens[2:0];
    assign prox      = snap_sens[4] | snap_sens[3];
    assign fr        = follow(line, prox, last_side);
    assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign nav_state = state;
    // BotInfo and the upper sensor bits have no consumer in this block
    assign unused_ok = ^{BotInfo, Sensors[7:5]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            upd_q     <= upd_sysregs;
            evt_d     <= 1'b0;
            snap_sens <= 5'd0;
            snap_loc  <= 16'd0;
            cnt       <= 8'd0;
            last_side <= 1'b0;
            MotCtl    <= STOP;
            upd_ack   <= 1'b0;
        end else begin
            upd_q   <= upd_sysregs;
            evt_d   <= evt;
            upd_ack <= 1'b0;
            if (evt) begin
                snap_loc  <= {LocX, LocY};
                snap_sens <= Sensors[4:0];
            end
            if (!enable) begin
                state  <= IDLE;
                MotCtl <= STOP;
                cnt    <= 8'd0;
            end else if (evt_d) begin
                upd_ack <= 1'b1;
                case (state)
                    IDLE, FOLLOW: begin
                        state     <= fr.st;
                        MotCtl    <= fr.mot;
                        cnt       <= fr.cnt;
                        last_side <= fr.side;
                    end
                    SEARCH: begin
                        if (prox || line != 3'b000) begin
                            state     <= fr.st;
                            MotCtl    <= fr.mot;
                            cnt       <= fr.cnt;
                            last_side <= fr.side;
                        end else if (cnt == SEARCH_LIMIT) begin
                            state  <= HALT;
                            MotCtl <= STOP;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    BACKUP: begin
                        if (cnt == BACK_UPDS) begin
                            state  <= TURN;
                            MotCtl <= SPIN_R;
                            cnt    <= 8'd1;
                        end else begin
                            MotCtl <= REV;
                            cnt    <= cnt_inc;
                        end
                    end
                    TURN: begin
                        if (prox) begin
                            state  <= BACKUP;
                            MotCtl <= REV;
                            cnt    <= 8'd1;
                        end else if (cnt == TURN_UPDS) begin
                            state     <= fr.st;
                            MotCtl    <= fr.mot;
                            cnt       <= fr.cnt;
                            last_side <= fr.side;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    HALT: begin
                        MotCtl <= STOP;
                    end
                    default: begin
                        state  <= IDLE;
                        MotCtl <= STOP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bot_nav_ctrl.sv
// Directed bench for bot_nav_ctrl: follow, search, backup/turn,
// enable override and mid-flight reset.
module tb_bot_nav_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        upd_sysregs;
    logic [7:0]  LocX;
    logic [7:0]  LocY;
    logic [7:0]  BotInfo;
    logic [7:0]  Sensors;
    logic [7:0]  MotCtl;
    logic [2:0]  nav_state;
    logic        upd_ack;
    logic [15:0] snap_loc;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    bot_nav_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .upd_sysregs(upd_sysregs),
        .LocX       (LocX),
        .LocY       (LocY),
        .BotInfo    (BotInfo),
        .Sensors    (Sensors),
        .MotCtl     (MotCtl),
        .nav_state  (nav_state),
        .upd_ack    (upd_ack),
        .snap_loc   (snap_loc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // toggle the update flag, then wait for the decision edge
    task automatic upd(input logic [7:0] s, input logic [7:0] x,
                       input logic [7:0] y);
        Sensors     = s;
        LocX        = x;
        LocY        = y;
        upd_sysregs = ~upd_sysregs;
        step();
        step();
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        upd_sysregs = 1'b1;
        LocX        = 8'h00;
        LocY        = 8'h00;
        BotInfo     = 8'h3C;
        Sensors     = 8'h07;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        chk("rst_ack", {15'd0, upd_ack}, 16'd0);
        chk("rst_mot", {8'd0, MotCtl}, 16'h0000);
        chk("rst_state", {13'd0, nav_state}, 16'd0);
        chk("rst_snap", snap_loc, 16'h0000);

        enable = 1'b1;
        upd(8'h05, 8'h10, 8'h20);
        chk("first_mot", {8'd0, MotCtl}, 16'h0077);
        chk("first_state", {13'd0, nav_state}, 16'd1);
        chk("first_snap", snap_loc, 16'h1020);
        chk("first_ack", {15'd0, upd_ack}, 16'd1);
        step();
        chk("first_ack_end", {15'd0, upd_ack}, 16'd0);

        upd(8'h03, 8'h11, 8'h21);
        chk("veer_l", {8'd0, MotCtl}, 16'h0057);
        upd(8'h07, 8'h12, 8'h22);
        chk("search_mot", {8'd0, MotCtl}, 16'h0045);
        chk("search_state", {13'd0, nav_state}, 16'd2);
        for (int i = 0; i < 31; i++) upd(8'h07, 8'h12, 8'h22);
        chk("search31_state", {13'd0, nav_state}, 16'd2);
        chk("search31_mot", {8'd0, MotCtl}, 16'h0045);
        upd(8'h07, 8'h12, 8'h22);
        chk("halt_state", {13'd0, nav_state}, 16'd5);
        chk("halt_mot", {8'd0, MotCtl}, 16'h0000);
        upd(8'h05, 8'h12, 8'h22);
        chk("halt_stays", {13'd0, nav_state}, 16'd5);

        enable = 1'b0;
        step();
        step();
        chk("dis_state", {13'd0, nav_state}, 16'd0);
        enable = 1'b1;
        upd(8'h06, 8'h30, 8'h40);
        chk("veer_r", {8'd0, MotCtl}, 16'h0075);
        upd(8'h07, 8'h30, 8'h40);
        chk("spin_r_search", {8'd0, MotCtl}, 16'h0054);
        upd(8'h05, 8'h31, 8'h41);
        chk("reacquire", {8'd0, MotCtl}, 16'h0077);
        chk("reacquire_st", {13'd0, nav_state}, 16'd1);

        upd(8'h15, 8'h32, 8'h42);
        chk("backup_state", {13'd0, nav_state}, 16'd3);
        chk("backup_mot", {8'd0, MotCtl}, 16'h0044);
        for (int i = 0; i < 3; i++) upd(8'h05, 8'h32, 8'h42);
        chk("backup3_state", {13'd0, nav_state}, 16'd3);
        chk("backup3_mot", {8'd0, MotCtl}, 16'h0044);
        upd(8'h05, 8'h32, 8'h42);
        chk("turn_state", {13'd0, nav_state}, 16'd4);
        chk("turn_mot", {8'd0, MotCtl}, 16'h0054);
        for (int i = 0; i < 5; i++) upd(8'h05, 8'h32, 8'h42);
        chk("turn5_state", {13'd0, nav_state}, 16'd4);
        upd(8'h05, 8'h33, 8'h43);
        chk("turn_done_st", {13'd0, nav_state}, 16'd1);
        chk("turn_done_mot", {8'd0, MotCtl}, 16'h0077);

        upd(8'h15, 8'h34, 8'h44);
        chk("backup2_state", {13'd0, nav_state}, 16'd3);
        enable      = 1'b0;
        upd_sysregs = ~upd_sysregs;
        step();
        chk("ovr_state", {13'd0, nav_state}, 16'd0);
        chk("ovr_mot", {8'd0, MotCtl}, 16'h0000);
        chk("ovr_ack", {15'd0, upd_ack}, 16'd0);
        step();
        chk("ovr_ack2", {15'd0, upd_ack}, 16'd0);

        enable = 1'b1;
        step();
        upd(8'h05, 8'h50, 8'h60);
        chk("pair1_ack", {15'd0, upd_ack}, 16'd1);
        chk("pair1_mot", {8'd0, MotCtl}, 16'h0077);
        upd(8'h01, 8'h51, 8'h61);
        chk("pair2_ack", {15'd0, upd_ack}, 16'd1);
        chk("pair2_mot", {8'd0, MotCtl}, 16'h0077);
        chk("pair2_snap", snap_loc, 16'h5161);
        step();
        chk("pair_ack_end", {15'd0, upd_ack}, 16'd0);

        upd_sysregs = ~upd_sysregs;
        Sensors     = 8'h15;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("mid_rst_ack", {15'd0, upd_ack}, 16'd0);
        chk("mid_rst_state", {13'd0, nav_state}, 16'd0);
        chk("mid_rst_snap", snap_loc, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
